// File: rtl/eggtimer_pkg.sv
// Shared definitions for the egg-timer countdown core.
//   state_t          : controller states (IDLE, RUN, PAUSED, DONE)
//   EGG_SEC_W        : default width of the second counters
//   EGG_MAX_SECONDS  : default saturation limit for a programmed duration (59:59)
//   EGG_CLK_HZ       : default system clock frequency
package eggtimer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int EGG_SEC_W       = 12;
    localparam int EGG_MAX_SECONDS = 3599;
    localparam int EGG_CLK_HZ      = 100_000_000;

endpackage

// File: rtl/countdown_timer_if.sv
// Bundle between the button/display stages and the countdown core.
//   set_seconds   : duration to program (sampled on load)
//   load          : pulse, program set_seconds
//   start_stop    : pulse, start / pause / resume
//   clear         : pulse, abort and reload the programmed duration
//   timer_seconds : seconds remaining
//   prog_seconds  : programmed duration
//   running       : 1 while counting
//   tick_1hz      : 1-cycle pulse on each decrement
//   done          : 1 once expired
//   alarm         : 1 Hz square wave while done
// master = button/display side, slave = countdown core.
interface countdown_timer_if
    import eggtimer_pkg::*;
#(
    parameter int SEC_W = EGG_SEC_W
);
    logic [SEC_W-1:0] set_seconds;
    logic             load;
    logic             start_stop;
    logic             clear;
    logic [SEC_W-1:0] timer_seconds;
    logic [SEC_W-1:0] prog_seconds;
    logic             running;
    logic             tick_1hz;
    logic             done;
    logic             alarm;

    modport master (
        output set_seconds, load, start_stop, clear,
        input  timer_seconds, prog_seconds, running, tick_1hz, done, alarm
    );

    modport slave (
        input  set_seconds, load, start_stop, clear,
        output timer_seconds, prog_seconds, running, tick_1hz, done, alarm
    );

endinterface

// File: rtl/sec_prescaler.sv
// One-second prescaler: counts 0..CLK_HZ-1 while enabled and wraps.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   en    : advance the count this cycle
//   clr   : force the count to 0 (wins over en)
//   count : current prescaler value
//   tick  : 1 in the enabled cycle where count sits at terminal count
module sec_prescaler
    import eggtimer_pkg::*;
#(
    parameter int CLK_HZ = EGG_CLK_HZ,
    localparam int CNT_W = $clog2(CLK_HZ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             tick
);

    assign tick = en && (count == CNT_W'(CLK_HZ - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= tick ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Egg-timer countdown core: holds the programmed duration, counts it down once
// per second, and flags expiry with done plus a 1 Hz alarm square wave.
//   clk     : system clock, all state on rising edge
//   reset_n : asynchronous active-low reset (released synchronously)
//   bus     : countdown_timer_if.slave (controls in, display/status out)
// Input priority per cycle: clear > load > start_stop.
module countdown_timer
    import eggtimer_pkg::*;
#(
    parameter int CLK_HZ      = EGG_CLK_HZ,
    parameter int SEC_W       = EGG_SEC_W,
    parameter int MAX_SECONDS = EGG_MAX_SECONDS
) (
    input  logic              clk,
    input  logic              reset_n,
    countdown_timer_if.slave  bus
);

    localparam int CNT_W = $clog2(CLK_HZ);

    logic [1:0]       rst_sync;
    logic             rst_n_int;
    state_t           state;
    state_t           state_nxt;
    logic [SEC_W-1:0] timer_q;
    logic [SEC_W-1:0] timer_nxt;
    logic [SEC_W-1:0] prog_q;
    logic [SEC_W-1:0] prog_nxt;
    logic             presc_en;
    logic             presc_clr;
    logic             presc_tick;
    logic [CNT_W-1:0] presc_count;

    function automatic logic [SEC_W-1:0] sat_seconds(input logic [SEC_W-1:0] v);
        if (32'(v) > 32'(MAX_SECONDS)) begin
            return SEC_W'(MAX_SECONDS);
        end
        return v;
    endfunction

    // Reset asserts immediately but releases two edges later, clean to clk.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n_int = rst_sync[1];

    // Prescaler keeps running in DONE so it can pace the alarm.
    assign presc_en = (state == ST_RUN) || (state == ST_DONE);

    sec_prescaler #(
        .CLK_HZ (CLK_HZ)
    ) u_sec_prescaler (
        .clk   (clk),
        .rst_n (rst_n_int),
        .en    (presc_en),
        .clr   (presc_clr),
        .count (presc_count),
        .tick  (presc_tick)
    );

    always_comb begin
        state_nxt = state;
        timer_nxt = timer_q;
        prog_nxt  = prog_q;
        presc_clr = 1'b0;

        if (bus.clear) begin
            state_nxt = ST_IDLE;
            timer_nxt = prog_q;
            presc_clr = 1'b1;
        end else if (bus.load && (state == ST_IDLE || state == ST_DONE)) begin
            prog_nxt  = sat_seconds(bus.set_seconds);
            timer_nxt = sat_seconds(bus.set_seconds);
            state_nxt = ST_IDLE;
            presc_clr = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start_stop && timer_q != '0) begin
                        state_nxt = ST_RUN;
                        presc_clr = 1'b1;
                    end
                end
                ST_RUN: begin
                    // A tick always lands; expiry beats a coincident pause.
                    if (presc_tick && timer_q != '0) begin
                        timer_nxt = timer_q - SEC_W'(1);
                    end
                    if (presc_tick && timer_q == SEC_W'(1)) begin
                        state_nxt = ST_DONE;
                    end else if (bus.start_stop) begin
                        state_nxt = ST_PAUSED;
                    end
                end
                ST_PAUSED: begin
                    // Resume keeps the prescaler phase, so no partial second is lost.
                    if (bus.start_stop) begin
                        state_nxt = ST_RUN;
                    end
                end
                ST_DONE: begin
                    state_nxt = ST_DONE;
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state   <= ST_IDLE;
            timer_q <= '0;
            prog_q  <= '0;
        end else begin
            state   <= state_nxt;
            timer_q <= timer_nxt;
            prog_q  <= prog_nxt;
        end
    end

    assign bus.timer_seconds = timer_q;
    assign bus.prog_seconds  = prog_q;
    assign bus.running       = (state == ST_RUN);
    assign bus.tick_1hz      = (state == ST_RUN) && presc_tick;
    assign bus.done          = (state == ST_DONE);
    assign bus.alarm         = (state == ST_DONE) && (presc_count < CNT_W'(CLK_HZ / 2));

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer at CLK_HZ=10: directed scenarios followed by
// randomized control pulses, all checked each cycle against a behavioural model.
module tb_countdown_timer;

    localparam int HZ   = 10;
    localparam int SW   = 12;
    localparam int MAXS = 3599;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;

    always #5 clk = ~clk;

    countdown_timer_if #(.SEC_W(SW)) bus ();

    countdown_timer #(
        .CLK_HZ      (HZ),
        .SEC_W       (SW),
        .MAX_SECONDS (MAXS)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model: seconds remaining, programmed seconds, cycles into current second,
    // and what the timer is doing (counting / on hold / expired / neither).
    int m_prog, m_timer, m_phase;
    bit m_counting, m_hold, m_expired;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic model_reset();
        m_prog = 0; m_timer = 0; m_phase = 0;
        m_counting = 0; m_hold = 0; m_expired = 0;
    endtask

    task automatic model_step(input bit c, input bit l, input bit s, input int v);
        int sat;
        sat = (v > MAXS) ? MAXS : v;
        if (c) begin
            m_timer = m_prog; m_phase = 0;
            m_counting = 0; m_hold = 0; m_expired = 0;
        end else if (l && !m_counting && !m_hold) begin
            m_prog = sat; m_timer = sat; m_phase = 0; m_expired = 0;
        end else if (m_counting) begin
            if (m_phase == HZ - 1) begin
                m_timer = m_timer - 1;
                m_phase = 0;
                if (m_timer == 0) begin m_counting = 0; m_expired = 1; end
                else if (s) begin m_counting = 0; m_hold = 1; end
            end else begin
                m_phase = m_phase + 1;
                if (s) begin m_counting = 0; m_hold = 1; end
            end
        end else if (m_hold) begin
            if (s) begin m_hold = 0; m_counting = 1; end
        end else if (m_expired) begin
            m_phase = (m_phase + 1) % HZ;
        end else if (s && m_timer != 0) begin
            m_counting = 1; m_phase = 0;
        end
    endtask

    task automatic check_outputs();
        check("timer",   32'(bus.timer_seconds), m_timer);
        check("prog",    32'(bus.prog_seconds),  m_prog);
        check("running", 32'(bus.running),       32'(m_counting));
        check("tick",    32'(bus.tick_1hz),      32'(m_counting && m_phase == HZ - 1));
        check("done",    32'(bus.done),          32'(m_expired));
        check("alarm",   32'(bus.alarm),         32'(m_expired && m_phase < HZ / 2));
        check("invariant", 32'(bus.timer_seconds <= bus.prog_seconds), 1);
    endtask

    // Called at a falling edge: drive inputs, cross one rising edge, check.
    task automatic step(input bit c, input bit l, input bit s, input int v);
        bus.clear       = c;
        bus.load        = l;
        bus.start_stop  = s;
        bus.set_seconds = SW'(v);
        model_step(c, l, s, v);
        @(posedge clk);
        @(negedge clk);
        bus.clear      = 1'b0;
        bus.load       = 1'b0;
        bus.start_stop = 1'b0;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0);
    endtask

    initial begin
        bus.clear = 1'b0; bus.load = 1'b0; bus.start_stop = 1'b0; bus.set_seconds = '0;
        model_reset();
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check_outputs();
        reset_n = 1'b1;
        idle(3);

        // Full countdown from 5, then alarm cadence in DONE.
        step(0, 1, 0, 5);
        check("t1_prog", 32'(bus.prog_seconds), 5);
        step(0, 0, 1, 0);
        check("t1_running", 32'(bus.running), 1);
        for (int i = 1; i <= 5; i++) begin
            idle(9);
            check("t1_tick", 32'(bus.tick_1hz), 1);
            idle(1);
            check("t1_timer", 32'(bus.timer_seconds), 5 - i);
        end
        check("t1_done", 32'(bus.done), 1);
        check("t1_alarm_hi", 32'(bus.alarm), 1);
        idle(5);
        check("t1_alarm_lo", 32'(bus.alarm), 0);
        idle(5);
        check("t1_alarm_hi2", 32'(bus.alarm), 1);

        // Zero duration cannot start; oversize load saturates.
        step(0, 1, 0, 0);
        check("t4_done_cleared", 32'(bus.done), 0);
        step(0, 0, 1, 0);
        check("t4_no_start", 32'(bus.running), 0);
        idle(12);
        step(0, 1, 0, 4095);
        check("t4_sat_prog", 32'(bus.prog_seconds), MAXS);
        check("t4_sat_timer", 32'(bus.timer_seconds), MAXS);

        // Pause 23 cycles after start, resume, next decrement 7 cycles later.
        step(0, 1, 0, 5);
        step(0, 0, 1, 0);
        idle(22);
        step(0, 0, 1, 0);
        check("t2_paused", 32'(bus.running), 0);
        check("t2_held", 32'(bus.timer_seconds), 3);
        idle(10);
        check("t2_still_held", 32'(bus.timer_seconds), 3);
        step(0, 0, 1, 0);
        idle(6);
        check("t2_before_dec", 32'(bus.timer_seconds), 3);
        idle(1);
        check("t2_after_dec", 32'(bus.timer_seconds), 2);

        // Clear from RUN at timer=2.
        step(1, 0, 0, 0);
        check("t3_timer", 32'(bus.timer_seconds), 5);
        check("t3_running", 32'(bus.running), 0);
        check("t3_done", 32'(bus.done), 0);

        // Load ignored in RUN; clear beats load.
        step(0, 0, 1, 0);
        idle(3);
        step(0, 1, 0, 7);
        check("t5_load_ignored", 32'(bus.prog_seconds), 5);
        step(1, 1, 0, 9);
        check("t5_clear_wins", 32'(bus.timer_seconds), 5);
        check("t5_prog_kept", 32'(bus.prog_seconds), 5);

        // Asynchronous reset between edges mid-RUN.
        step(0, 0, 1, 0);
        idle(14);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        reset_n = 1'b1;
        idle(4);
        check("t6_idle", 32'(bus.running), 0);

        // Randomized control pulses.
        for (int i = 0; i < 3000; i++) begin
            int r, v;
            bit c, l, s;
            r = $urandom_range(0, 99);
            c = (r < 2);
            l = (r >= 2 && r < 6);
            s = (r >= 6 && r < 14);
            v = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 4095) : $urandom_range(0, 6);
            step(c, l, s, v);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
